// File: rtl/mac_arbiter_pkg.sv
// Shared defaults and helpers for the round-robin MAC arbiter.
// Holds the parameter defaults and the requester-id width used by the top and rr_pick.
package mac_arbiter_pkg;

    localparam int unsigned N_REQ_DEF = 4;
    localparam int unsigned DW_DEF    = 24;
    localparam int unsigned OW_DEF    = 48;
    localparam int unsigned LAT_DEF   = 2;

    // A single requester still needs a 1-bit id so that no signal ends up zero-width.
    function automatic int unsigned id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned ID_W_DEF = id_width(N_REQ_DEF);

endpackage

// File: rtl/mac_arbiter_rr_pick.sv
// Round-robin winner search: the first requester at or above rr_ptr, wrapping at N_REQ.
// Purely combinational; gnt is one-hot, or zero when nothing is requested.
module mac_arbiter_rr_pick
    import mac_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ = N_REQ_DEF,
    parameter int unsigned IdW   = id_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IdW-1:0]   rr_ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [IdW-1:0]   winner
);

    logic found;

    always_comb begin
        gnt    = '0;
        winner = '0;
        found  = 1'b0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            int idx;
            idx = int'(rr_ptr) + i;
            if (idx >= int'(N_REQ)) begin
                idx = idx - int'(N_REQ);
            end
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                winner   = IdW'(idx);
            end
        end
    end

endmodule

// File: rtl/mac_arbiter.sv
// Shares one external A*B+C ALU among N_REQ requesters with round-robin arbitration.
// A tag pipeline follows each issued operation so its result returns to the owning requester.
module mac_arbiter
    import mac_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ = N_REQ_DEF,
    parameter int unsigned DW    = DW_DEF,
    parameter int unsigned OW    = OW_DEF,
    parameter int unsigned LAT   = LAT_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ*DW-1:0] a_bus,
    input  logic [N_REQ*DW-1:0] b_bus,
    input  logic [N_REQ*DW-1:0] c_bus,
    input  logic                hold,
    output logic [N_REQ-1:0]    gnt,
    output logic [DW-1:0]       alu_a,
    output logic [DW-1:0]       alu_b,
    output logic [DW-1:0]       alu_c,
    input  logic [OW-1:0]       alu_dout,
    output logic [N_REQ-1:0]    rsp_valid,
    output logic [OW-1:0]       rsp_data,
    output logic                idle
);

    localparam int unsigned IdW = id_width(N_REQ);

    logic [IdW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [DW-1:0]    alu_a_q, alu_a_d;
    logic [DW-1:0]    alu_b_q, alu_b_d;
    logic [DW-1:0]    alu_c_q, alu_c_d;
    logic [OW-1:0]    rsp_data_q, rsp_data_d;
    logic [LAT:0]     tag_vld_q, tag_vld_d;
    logic [IdW-1:0]   tag_id_q [0:LAT];
    logic [IdW-1:0]   tag_id_d [0:LAT];

    logic [N_REQ-1:0] req_elig;
    logic [IdW-1:0]   winner;
    logic             gnt_any;

    // Reset and hold both mask the request vector so no grant can be issued.
    assign req_elig = (rst || hold) ? '0 : req;

    mac_arbiter_rr_pick #(
        .N_REQ (N_REQ),
        .IdW   (IdW)
    ) u_rr_pick (
        .req    (req_elig),
        .rr_ptr (rr_ptr_q),
        .gnt    (gnt),
        .winner (winner)
    );

    assign gnt_any = |gnt;

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        alu_a_d  = alu_a_q;
        alu_b_d  = alu_b_q;
        alu_c_d  = alu_c_q;
        if (gnt_any) begin
            rr_ptr_d = (winner == IdW'(N_REQ - 1)) ? '0 : winner + IdW'(1);
            alu_a_d  = a_bus[winner*DW +: DW];
            alu_b_d  = b_bus[winner*DW +: DW];
            alu_c_d  = c_bus[winner*DW +: DW];
        end
    end

    // Stage k is valid in cycle G+1+k; the final stage is the response cycle G+LAT+1.
    always_comb begin
        tag_vld_d    = {tag_vld_q[LAT-1:0], gnt_any};
        tag_id_d[0]  = winner;
        for (int k = 1; k <= int'(LAT); k++) begin
            tag_id_d[k] = tag_id_q[k-1];
        end
    end

    // The ALU result for a tag is valid one cycle before that tag reaches the last stage.
    always_comb begin
        rsp_data_d = rsp_data_q;
        if (tag_vld_q[LAT-1]) begin
            rsp_data_d = alu_dout;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q   <= '0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_c_q    <= '0;
            rsp_data_q <= '0;
            tag_vld_q  <= '0;
            for (int k = 0; k <= int'(LAT); k++) begin
                tag_id_q[k] <= '0;
            end
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_c_q    <= alu_c_d;
            rsp_data_q <= rsp_data_d;
            tag_vld_q  <= tag_vld_d;
            for (int k = 0; k <= int'(LAT); k++) begin
                tag_id_q[k] <= tag_id_d[k];
            end
        end
    end

    always_comb begin
        rsp_valid = '0;
        if (tag_vld_q[LAT]) begin
            rsp_valid[tag_id_q[LAT]] = 1'b1;
        end
    end

    assign alu_a    = alu_a_q;
    assign alu_b    = alu_b_q;
    assign alu_c    = alu_c_q;
    assign rsp_data = rsp_data_q;
    assign idle     = ~(|tag_vld_q) & ~gnt_any;

endmodule

// File: tb/tb_mac_arbiter.sv
// Directed bench for mac_arbiter with a behavioural signed A*B+C ALU of latency 2.
module tb_mac_arbiter;

    localparam int N  = 4;
    localparam int DW = 24;
    localparam int OW = 48;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req;
    logic [N*DW-1:0] a_bus, b_bus, c_bus;
    logic          hold;
    logic [N-1:0]  gnt;
    logic [DW-1:0] alu_a, alu_b, alu_c;
    logic [OW-1:0] alu_dout;
    logic [N-1:0]  rsp_valid;
    logic [OW-1:0] rsp_data;
    logic          idle;

    int n_cmp  = 0;
    int n_fail = 0;

    mac_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .a_bus     (a_bus),
        .b_bus     (b_bus),
        .c_bus     (c_bus),
        .hold      (hold),
        .gnt       (gnt),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_c     (alu_c),
        .alu_dout  (alu_dout),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .idle      (idle)
    );

    always #5 clk = ~clk;

    function automatic logic [OW-1:0] alu_model(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                                input logic [DW-1:0] c);
        logic signed [OW-1:0] sa, sb, sc;
        sa = {{(OW-DW){a[DW-1]}}, a};
        sb = {{(OW-DW){b[DW-1]}}, b};
        sc = {{(OW-DW){c[DW-1]}}, c};
        return sa * sb + sc;
    endfunction

    // Operands registered at edge E, one internal stage, result sampled by the DUT at E+2.
    always @(posedge clk) alu_dout <= alu_model(alu_a, alu_b, alu_c);

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b,
                           input logic [DW-1:0] c);
        a_bus[i*DW +: DW] = a;
        b_bus[i*DW +: DW] = b;
        c_bus[i*DW +: DW] = c;
    endtask

    // Requester i: A=i+1, B=i+2, C=i -> results 2, 7, 14, 23.
    task automatic load_default_ops();
        for (int i = 0; i < N; i++) begin
            set_ops(i, DW'(i + 1), DW'(i + 2), DW'(i));
        end
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        req  = '0;
        hold = 1'b0;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_cmp++; if (idle !== 1'b1) begin n_fail++; $display("FAIL reset_idle: got %b want 1", idle); end
        n_cmp++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
        n_cmp++; if (rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 0000", rsp_valid); end
        n_cmp++; if (rsp_data !== 48'h0) begin n_fail++; $display("FAIL reset_rsp_data: got %h want 0", rsp_data); end
        n_cmp++; if ({alu_a, alu_b, alu_c} !== 72'h0) begin n_fail++; $display("FAIL reset_alu_ops: got %h want 0", {alu_a, alu_b, alu_c}); end
        rst = 1'b1;
        #1;
        n_cmp++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt_masked: got %b want 0000", gnt); end
        rst = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        load_default_ops();
        set_ops(2, 24'd3, 24'd5, 24'd1);
        for (int c = 0; c <= 4; c++) begin
            req = (c == 0) ? 4'b0100 : 4'b0000;
            #1;
            if (c == 0) begin
                n_cmp++; if (gnt !== 4'b0100) begin n_fail++; $display("FAIL single_gnt: got %b want 0100", gnt); end
            end
            if (c == 1) begin
                n_cmp++; if (alu_a !== 24'd3 || alu_b !== 24'd5 || alu_c !== 24'd1) begin
                    n_fail++; $display("FAIL single_ops: got %0d %0d %0d want 3 5 1", alu_a, alu_b, alu_c); end
            end
            if (c == 3) begin
                n_cmp++; if (rsp_valid !== 4'b0100) begin n_fail++; $display("FAIL single_rsp_valid: got %b want 0100", rsp_valid); end
                n_cmp++; if (rsp_data !== 48'd16) begin n_fail++; $display("FAIL single_rsp_data: got %0d want 16", rsp_data); end
            end else begin
                n_cmp++; if (rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL single_no_rsp c%0d: got %b want 0000", c, rsp_valid); end
            end
            if (c == 4) begin
                n_cmp++; if (idle !== 1'b1) begin n_fail++; $display("FAIL single_idle: got %b want 1", idle); end
                n_cmp++; if (rsp_data !== 48'd16) begin n_fail++; $display("FAIL single_data_hold: got %0d want 16", rsp_data); end
            end else begin
                n_cmp++; if (idle !== 1'b0) begin n_fail++; $display("FAIL single_busy c%0d: got %b want 0", c, idle); end
            end
            cyc();
        end
    endtask

    task automatic test_back_to_back();
        logic [N-1:0]  exp_v;
        logic [OW-1:0] exp_d [N];
        exp_d = '{48'd2, 48'd7, 48'd14, 48'd23};
        do_reset();
        load_default_ops();
        for (int c = 0; c <= 11; c++) begin
            req = (c < 8) ? 4'b1111 : 4'b0000;
            #1;
            exp_v = (c < 8) ? 4'(1 << (c % 4)) : 4'b0000;
            n_cmp++; if (gnt !== exp_v) begin n_fail++; $display("FAIL b2b_gnt c%0d: got %b want %b", c, gnt, exp_v); end
            exp_v = (c >= 3 && c <= 10) ? 4'(1 << ((c - 3) % 4)) : 4'b0000;
            n_cmp++; if (rsp_valid !== exp_v) begin n_fail++; $display("FAIL b2b_rsp_valid c%0d: got %b want %b", c, rsp_valid, exp_v); end
            if (c >= 3 && c <= 10) begin
                n_cmp++; if (rsp_data !== exp_d[(c - 3) % 4]) begin
                    n_fail++; $display("FAIL b2b_rsp_data c%0d: got %0d want %0d", c, rsp_data, exp_d[(c - 3) % 4]); end
            end
            cyc();
        end
    endtask

    task automatic test_hold();
        logic [N-1:0] exp_v;
        do_reset();
        load_default_ops();
        for (int c = 0; c <= 6; c++) begin
            req  = 4'b1111;
            hold = (c >= 2);
            #1;
            exp_v = (c < 2) ? 4'(1 << c) : 4'b0000;
            n_cmp++; if (gnt !== exp_v) begin n_fail++; $display("FAIL hold_gnt c%0d: got %b want %b", c, gnt, exp_v); end
            exp_v = (c == 3) ? 4'b0001 : (c == 4) ? 4'b0010 : 4'b0000;
            n_cmp++; if (rsp_valid !== exp_v) begin n_fail++; $display("FAIL hold_rsp_valid c%0d: got %b want %b", c, rsp_valid, exp_v); end
            n_cmp++; if (idle !== (c >= 5)) begin n_fail++; $display("FAIL hold_idle c%0d: got %b want %b", c, idle, (c >= 5)); end
            cyc();
        end
        hold = 1'b0;
        req  = '0;
    endtask

    task automatic test_reset_in_flight();
        do_reset();
        load_default_ops();
        for (int c = 0; c <= 7; c++) begin
            rst = (c == 2);
            req = (c < 3) ? 4'b1111 : (c == 7) ? 4'b1010 : 4'b0000;
            #1;
            if (c == 2) begin
                n_cmp++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL rif_gnt_in_rst: got %b want 0000", gnt); end
            end
            if (c >= 3 && c <= 6) begin
                n_cmp++; if (rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL rif_dropped c%0d: got %b want 0000", c, rsp_valid); end
                n_cmp++; if (idle !== 1'b1) begin n_fail++; $display("FAIL rif_idle c%0d: got %b want 1", c, idle); end
            end
            if (c == 7) begin
                n_cmp++; if (gnt !== 4'b0010) begin n_fail++; $display("FAIL rif_ptr_cleared: got %b want 0010", gnt); end
            end
            cyc();
        end
        req = '0;
    endtask

    task automatic test_fairness();
        logic [N-1:0] exp_v;
        do_reset();
        load_default_ops();
        for (int c = 0; c < 6; c++) begin
            req = 4'b1001;
            #1;
            exp_v = (c % 2 == 0) ? 4'b0001 : 4'b1000;
            n_cmp++; if (gnt !== exp_v) begin n_fail++; $display("FAIL fair_gnt c%0d: got %b want %b", c, gnt, exp_v); end
            cyc();
        end
        req = '0;
        repeat (4) cyc();
    endtask

    task automatic test_full_scale();
        do_reset();
        load_default_ops();
        set_ops(0, 24'h800000, 24'h7FFFFF, 24'h000000);
        for (int c = 0; c <= 3; c++) begin
            req = (c == 0) ? 4'b0001 : 4'b0000;
            #1;
            if (c == 3) begin
                n_cmp++; if (rsp_valid !== 4'b0001) begin n_fail++; $display("FAIL fs_rsp_valid: got %b want 0001", rsp_valid); end
                n_cmp++; if (rsp_data !== 48'hC00000800000) begin
                    n_fail++; $display("FAIL fs_rsp_data: got %h want c00000800000", rsp_data); end
            end
            cyc();
        end
    endtask

    initial begin
        rst      = 1'b1;
        req      = '0;
        hold     = 1'b0;
        a_bus    = '0;
        b_bus    = '0;
        c_bus    = '0;
        alu_dout = '0;
        cyc();
        test_reset();
        test_single();
        test_back_to_back();
        test_hold();
        test_reset_in_flight();
        test_fairness();
        test_full_scale();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
